// File: rtl/uart_rx.sv
// 16x-oversampled serial receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a small FIFO that is read through a ren/data/ready port.
module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic        ren,
  output logic [15:0] data,
  output logic        ready,
  output logic        overrun,
  output logic        frame_err,
`ifdef UART_RX_PARITY_EN
  output logic        parity_err,
`endif
  input  logic        clr_err,
  output logic [2:0]  fsm_state
);

  localparam int OSR_DIV = CLK_HZ / (BAUD * 16);
  localparam int TW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OSR_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic          rx_s1, rxs, rxs_d;
  logic [TW-1:0] tcnt;
  logic          tick, tick_clr;
  logic [3:0]    s_cnt, s_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, set_frame;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_n, set_par;
`endif

  assign fsm_state = state;

  // Synchroniser flops preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
    end
  end

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             tcnt <= '0;
    else if (tick_clr || tick) tcnt <= '0;
    else                      tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      s_cnt   <= s_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tick_clr  = 1'b0;
    push      = 1'b0;
    set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    set_par   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rxs_d && !rxs) begin
          state_n  = S_START;
          s_cnt_n  = '0;
          tick_clr = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_cnt == 4'd7) begin
            s_cnt_n = '0;
            if (rxs) begin
              state_n = S_IDLE;
            end else begin
              state_n   = S_DATA;
              bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
              par_bad_n = 1'b0;
`endif
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_cnt == 4'd15) begin
            s_cnt_n = '0;
            shreg_n = {rxs, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (s_cnt == 4'd15) begin
            s_cnt_n = '0;
            state_n = S_STOP;
            // Even parity: data bits plus parity bit must have an even count of ones.
            if ((^shreg) != rxs) begin
              set_par   = 1'b1;
              par_bad_n = 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (s_cnt == 4'd15) begin
            s_cnt_n = '0;
            if (rxs) begin
              state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
              push    = !par_bad;
`else
              push    = 1'b1;
`endif
            end else begin
              state_n   = S_BREAK;
              set_frame = 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FIFO: pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, do_pop, do_push, drop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = ren && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  assign ready = !empty;
  assign data  = empty ? 16'h0000 : {8'h00, mem[rptr[AW-1:0]]};

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= drop      ? 1'b1 : (clr_err ? 1'b0 : overrun);
      frame_err <= set_frame ? 1'b1 : (clr_err ? 1'b0 : frame_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else          parity_err <= set_par ? 1'b1 : (clr_err ? 1'b0 : parity_err);
  end
`endif

endmodule
